// File: rtl/axis_pipeline_register.sv
// AXI4-Stream register slice: skid buffer (MODE 0), simple register (MODE 1) or bypass (MODE 2).
// Disabled sideband fields are tied to zero at the master side.
module axis_pipeline_register #(
    parameter int MODE           = 0,
    parameter int TREADY_RST_VAL = 0,
    parameter int ENABLE_TKEEP   = 1,
    parameter int ENABLE_TLAST   = 1,
    parameter int ENABLE_TID     = 0,
    parameter int ENABLE_TDEST   = 0,
    parameter int ENABLE_TUSER   = 0,
    parameter int TDATA_WIDTH    = 32,
    parameter int TUSER_WIDTH    = 1,
    parameter int TID_WIDTH      = 8,
    parameter int TDEST_WIDTH    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     s_tready,
    input  logic                     s_tvalid,
    input  logic [TDATA_WIDTH-1:0]   s_tdata,
    input  logic [TDATA_WIDTH/8-1:0] s_tkeep,
    input  logic                     s_tlast,
    input  logic [TID_WIDTH-1:0]     s_tid,
    input  logic [TDEST_WIDTH-1:0]   s_tdest,
    input  logic [TUSER_WIDTH-1:0]   s_tuser,
    input  logic                     m_tready,
    output logic                     m_tvalid,
    output logic [TDATA_WIDTH-1:0]   m_tdata,
    output logic [TDATA_WIDTH/8-1:0] m_tkeep,
    output logic                     m_tlast,
    output logic [TID_WIDTH-1:0]     m_tid,
    output logic [TDEST_WIDTH-1:0]   m_tdest,
    output logic [TUSER_WIDTH-1:0]   m_tuser
);
    localparam int KEEP_WIDTH    = TDATA_WIDTH / 8;
    localparam int PAYLOAD_WIDTH = TDATA_WIDTH + KEEP_WIDTH + 1 + TID_WIDTH + TDEST_WIDTH + TUSER_WIDTH;
    localparam logic RST_READY   = (TREADY_RST_VAL != 0);

    logic [PAYLOAD_WIDTH-1:0] s_payload;
    logic [PAYLOAD_WIDTH-1:0] m_payload;
    logic                     m_valid;

    logic [TDATA_WIDTH-1:0] m_data;
    logic [KEEP_WIDTH-1:0]  m_keep;
    logic                   m_last;
    logic [TID_WIDTH-1:0]   m_id;
    logic [TDEST_WIDTH-1:0] m_dest;
    logic [TUSER_WIDTH-1:0] m_user;

    assign s_payload = {s_tdata, s_tkeep, s_tlast, s_tid, s_tdest, s_tuser};
    assign {m_data, m_keep, m_last, m_id, m_dest, m_user} = m_payload;

    assign m_tvalid = m_valid;
    assign m_tdata  = m_data;
    assign m_tkeep  = (ENABLE_TKEEP != 0) ? m_keep : '0;
    assign m_tlast  = (ENABLE_TLAST != 0) ? m_last : 1'b0;
    assign m_tid    = (ENABLE_TID   != 0) ? m_id   : '0;
    assign m_tdest  = (ENABLE_TDEST != 0) ? m_dest : '0;
    assign m_tuser  = (ENABLE_TUSER != 0) ? m_user : '0;

    if (MODE == 0) begin : g_skid
        logic                     out_valid;
        logic                     skid_valid;
        logic                     ready_q;
        logic                     out_valid_next;
        logic                     skid_valid_next;
        logic                     load_out_from_in;
        logic                     load_out_from_skid;
        logic                     load_skid;
        logic                     in_fire;
        logic                     out_free;
        logic [PAYLOAD_WIDTH-1:0] out_payload;
        logic [PAYLOAD_WIDTH-1:0] skid_payload;

        assign in_fire  = s_tvalid && ready_q;
        assign out_free = !out_valid || m_tready;

        always_comb begin
            // NOTE: every output gets a default first so no path can infer a latch.
            out_valid_next     = out_valid;
            skid_valid_next    = skid_valid;
            load_out_from_in   = 1'b0;
            load_out_from_skid = 1'b0;
            load_skid          = 1'b0;
            if (out_free) begin
                // ready_q is low whenever the skid holds a beat, so no input competes here
                if (skid_valid) begin
                    load_out_from_skid = 1'b1;
                    out_valid_next     = 1'b1;
                    skid_valid_next    = 1'b0;
                end else begin
                    load_out_from_in = in_fire;
                    out_valid_next   = in_fire;
                end
            end else if (in_fire) begin
                load_skid       = 1'b1;
                skid_valid_next = 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            // NOTE: sequential state uses non-blocking assignments only.
            if (rst) begin
                out_valid  <= 1'b0;
                skid_valid <= 1'b0;
                ready_q    <= 1'b1;
            end else begin
                out_valid  <= out_valid_next;
                skid_valid <= skid_valid_next;
                ready_q    <= !skid_valid_next;
            end
        end

        // NOTE: payload registers carry no reset; the valid flags qualify them.
        always_ff @(posedge clk) begin
            if (load_out_from_skid) begin
                out_payload <= skid_payload;
            end else if (load_out_from_in) begin
                out_payload <= s_payload;
            end
            if (load_skid) begin
                skid_payload <= s_payload;
            end
        end

        // rst only overrides the flop value while asserted; m_tready never reaches s_tready
        assign s_tready  = rst ? RST_READY : ready_q;
        assign m_valid   = out_valid;
        assign m_payload = out_payload;
    end else if (MODE == 1) begin : g_simple
        logic                     out_valid;
        logic                     ready;
        logic [PAYLOAD_WIDTH-1:0] out_payload;

        assign ready = !out_valid || m_tready;

        always_ff @(posedge clk) begin
            if (rst) begin
                out_valid <= 1'b0;
            end else if (ready) begin
                out_valid <= s_tvalid;
            end
        end

        always_ff @(posedge clk) begin
            if (ready && s_tvalid) begin
                out_payload <= s_payload;
            end
        end

        assign s_tready  = rst ? RST_READY : ready;
        assign m_valid   = out_valid;
        assign m_payload = out_payload;
    end else begin : g_bypass
        assign s_tready  = m_tready;
        assign m_valid   = s_tvalid;
        assign m_payload = s_payload;
    end

endmodule

// File: tb/tb_axis_pipeline_register.sv
// Directed bench for axis_pipeline_register: skid (both reset-ready values), simple and bypass
// instances share one set of stimulus inputs; each scenario checks only the instance it targets.
module tb_axis_pipeline_register;
    localparam int DW  = 32;
    localparam int KW  = DW / 8;
    localparam int UW  = 16;
    localparam int SK0 = 0;
    localparam int SK1 = 1;
    localparam int SIM = 2;
    localparam int BYP = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_tvalid = 1'b0;
    logic [DW-1:0] s_tdata = '0;
    logic [KW-1:0] s_tkeep = '1;
    logic          s_tlast = 1'b0;
    logic [7:0]    s_tid = 8'h5a;
    logic [7:0]    s_tdest = 8'h3c;
    logic [UW-1:0] s_tuser = '0;
    logic          m_tready = 1'b1;

    logic          rdy  [4];
    logic          vld  [4];
    logic [DW-1:0] dat  [4];
    logic [KW-1:0] keep [4];
    logic          last [4];
    logic [7:0]    tid  [4];
    logic [7:0]    tdest[4];
    logic [UW-1:0] tuser[4];

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    axis_pipeline_register #(.MODE(0), .TREADY_RST_VAL(0), .TUSER_WIDTH(UW)) u_skid0 (
        .clk(clk), .rst(rst), .s_tready(rdy[SK0]), .s_tvalid(s_tvalid), .s_tdata(s_tdata),
        .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tid(s_tid), .s_tdest(s_tdest), .s_tuser(s_tuser),
        .m_tready(m_tready), .m_tvalid(vld[SK0]), .m_tdata(dat[SK0]), .m_tkeep(keep[SK0]),
        .m_tlast(last[SK0]), .m_tid(tid[SK0]), .m_tdest(tdest[SK0]), .m_tuser(tuser[SK0]));

    axis_pipeline_register #(.MODE(0), .TREADY_RST_VAL(1), .TUSER_WIDTH(UW)) u_skid1 (
        .clk(clk), .rst(rst), .s_tready(rdy[SK1]), .s_tvalid(s_tvalid), .s_tdata(s_tdata),
        .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tid(s_tid), .s_tdest(s_tdest), .s_tuser(s_tuser),
        .m_tready(m_tready), .m_tvalid(vld[SK1]), .m_tdata(dat[SK1]), .m_tkeep(keep[SK1]),
        .m_tlast(last[SK1]), .m_tid(tid[SK1]), .m_tdest(tdest[SK1]), .m_tuser(tuser[SK1]));

    axis_pipeline_register #(.MODE(1), .ENABLE_TUSER(1), .TUSER_WIDTH(UW)) u_simple (
        .clk(clk), .rst(rst), .s_tready(rdy[SIM]), .s_tvalid(s_tvalid), .s_tdata(s_tdata),
        .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tid(s_tid), .s_tdest(s_tdest), .s_tuser(s_tuser),
        .m_tready(m_tready), .m_tvalid(vld[SIM]), .m_tdata(dat[SIM]), .m_tkeep(keep[SIM]),
        .m_tlast(last[SIM]), .m_tid(tid[SIM]), .m_tdest(tdest[SIM]), .m_tuser(tuser[SIM]));

    axis_pipeline_register #(.MODE(2), .ENABLE_TUSER(0), .TUSER_WIDTH(UW)) u_bypass (
        .clk(clk), .rst(rst), .s_tready(rdy[BYP]), .s_tvalid(s_tvalid), .s_tdata(s_tdata),
        .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tid(s_tid), .s_tdest(s_tdest), .s_tuser(s_tuser),
        .m_tready(m_tready), .m_tvalid(vld[BYP]), .m_tdata(dat[BYP]), .m_tkeep(keep[BYP]),
        .m_tlast(last[BYP]), .m_tid(tid[BYP]), .m_tdest(tdest[BYP]), .m_tuser(tuser[BYP]));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge, inputs settle 1 unit after driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [48:0] exp_q[$];
        logic [48:0] exp_beat;
        int          sent;
        int          rcvd;
        int          cycles;

        // Reset with a beat offered: ready follows TREADY_RST_VAL, nothing is captured
        rst      = 1'b1;
        s_tvalid = 1'b1;
        s_tdata  = 32'hdead_beef;
        m_tready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rst_ready_val0", rdy[SK0], 1'b0);
            check("rst_ready_val1", rdy[SK1], 1'b1);
            check("rst_valid_val0", vld[SK0], 1'b0);
            check("rst_valid_val1", vld[SK1], 1'b0);
        end
        rst      = 1'b0;
        s_tvalid = 1'b0;
        settle();
        check("post_rst_ready0", rdy[SK0], 1'b1);
        check("post_rst_ready1", rdy[SK1], 1'b1);
        check("post_rst_valid0", vld[SK0], 1'b0);
        check("post_rst_valid1", vld[SK1], 1'b0);
        tick();
        check("rst_beat_dropped0", vld[SK0], 1'b0);
        check("rst_beat_dropped1", vld[SK1], 1'b0);

        // Skid: continuous stream 1..8 with the sink always ready
        m_tready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = DW'(i);
            settle();
            check("stream_ready", rdy[SK0], 1'b1);
            tick();
            check("stream_valid", vld[SK0], 1'b1);
            check("stream_data", dat[SK0], 64'(i));
        end
        s_tvalid = 1'b0;
        tick();
        check("stream_idle", vld[SK0], 1'b0);

        // Skid: stall after beat 1, beat 2 lands in the skid, beat 3 is refused
        m_tready = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = 32'd1;
        tick();
        check("stall_b1_valid", vld[SK0], 1'b1);
        check("stall_b1_data", dat[SK0], 64'd1);
        check("stall_b1_ready", rdy[SK0], 1'b1);
        s_tdata = 32'd2;
        tick();
        check("skid_ready_drop", rdy[SK0], 1'b0);
        check("skid_hold_data", dat[SK0], 64'd1);
        s_tdata = 32'd3;
        tick();
        check("skid_full_ready", rdy[SK0], 1'b0);
        check("skid_full_data", dat[SK0], 64'd1);
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        tick();
        check("drain_b2_valid", vld[SK0], 1'b1);
        check("drain_b2_data", dat[SK0], 64'd2);
        check("drain_ready_back", rdy[SK0], 1'b1);
        tick();
        check("drain_empty", vld[SK0], 1'b0);

        // Skid: fill both entries, then a one-cycle reset flushes them
        m_tready = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = 32'haaaa_0001;
        tick();
        s_tdata = 32'haaaa_0002;
        tick();
        check("flush_full_ready", rdy[SK0], 1'b0);
        check("flush_full_valid", vld[SK0], 1'b1);
        rst      = 1'b1;
        s_tvalid = 1'b0;
        settle();
        check("flush_rst_ready", rdy[SK0], 1'b0);
        tick();
        check("flush_valid_low", vld[SK0], 1'b0);
        rst      = 1'b0;
        m_tready = 1'b1;
        settle();
        check("flush_ready_back", rdy[SK0], 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("flush_no_ghost", vld[SK0], 1'b0);
        end

        // Simple register: random traffic, scoreboard on data/tlast/tuser order
        rst = 1'b1;
        tick();
        rst    = 1'b0;
        sent   = 0;
        rcvd   = 0;
        cycles = 0;
        while (rcvd < 1000 && cycles < 20000) begin
            s_tvalid = (sent < 1000) && ($urandom_range(0, 1) == 1);
            s_tdata  = $urandom;
            s_tlast  = (sent % 4) == 3;
            s_tuser  = sent[UW-1:0];
            m_tready = $urandom_range(0, 1) == 1;
            settle();
            check("simple_ready", rdy[SIM], !vld[SIM] || m_tready);
            if (vld[SIM] && m_tready) begin
                if (exp_q.size() == 0) begin
                    check("simple_spurious", 1'b1, 1'b0);
                end else begin
                    exp_beat = exp_q.pop_front();
                    check("simple_beat", {tuser[SIM], last[SIM], dat[SIM]}, exp_beat);
                    rcvd++;
                end
            end
            if (s_tvalid && rdy[SIM]) begin
                exp_q.push_back({s_tuser, s_tlast, s_tdata});
                sent++;
            end
            tick();
            cycles++;
        end
        check("simple_count", rcvd, 1000);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;

        // Bypass: zero latency, tuser disabled reads zero, rst ignored
        s_tvalid = 1'b1;
        s_tdata  = 32'ha5a5_0001;
        s_tkeep  = 4'h3;
        s_tlast  = 1'b1;
        s_tuser  = 16'hbeef;
        m_tready = 1'b0;
        settle();
        check("byp_valid", vld[BYP], 1'b1);
        check("byp_data", dat[BYP], 64'ha5a5_0001);
        check("byp_keep", keep[BYP], 64'h3);
        check("byp_last", last[BYP], 1'b1);
        check("byp_ready", rdy[BYP], 1'b0);
        check("byp_tuser_off", tuser[BYP], 64'h0);
        check("byp_tid_off", tid[BYP], 64'h0);
        rst      = 1'b1;
        s_tvalid = 1'b0;
        s_tdata  = 32'h1234_5678;
        s_tkeep  = 4'hc;
        s_tlast  = 1'b0;
        s_tuser  = 16'hffff;
        m_tready = 1'b1;
        settle();
        check("byp_rst_valid", vld[BYP], 1'b0);
        check("byp_rst_data", dat[BYP], 64'h1234_5678);
        check("byp_rst_keep", keep[BYP], 64'hc);
        check("byp_rst_last", last[BYP], 1'b0);
        check("byp_rst_ready", rdy[BYP], 1'b1);
        check("byp_rst_tuser", tuser[BYP], 64'h0);
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
